uart_msg_streamer: RTL and testbench
====================================

UART_MSG_STREAMER -- requirements
Module: uart_msg_streamer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, message-memory address width.
REQ-002 SHALL have parameter MAX_LEN, default 127, maximum bytes sent per message.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, idle clocks between bytes (0 allowed).
REQ-004 SHALL have parameter TERM_BYTE, default 8'h00, message terminator.
REQ-005 SHALL have parameters SKIP0/SKIP1, defaults 8'hE4/8'hFF, bytes fetched but never transmitted.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset; start in 1 begin-message pulse; msg_base in ADDR_WIDTH first byte address; abort in 1 stop request.
REQ-007 SHALL have ports: mem_addr out ADDR_WIDTH; mem_data in 8, valid exactly 1 clk after mem_addr.
REQ-008 SHALL have AXI-Lite write ports: awaddr out 4, awvalid out, awready in, wdata out 8, wvalid out, wready in, bresp in 2, bvalid in, bready out.
REQ-009 SHALL have AXI-Lite read ports: araddr out 4, arvalid out, arready in, rdata in 8, rresp in 2, rvalid in, rready out.
REQ-010 SHALL have status ports: busy out 1, done out 1 (pulse), err out 1 (sticky), sent_cnt out 8.
REQ-011 Reset rst SHALL be asynchronous, active-high; clock clk; all logic on rising clk.

Function
REQ-012 States SHALL be IDLE, FETCH, EVAL, POLL_AR, POLL_R, WRITE, RESP, GAP, DONE.
REQ-013 IDLE: busy=0; start=1 -> load addr=msg_base, sent_cnt=0, clear err, go FETCH; start ignored outside IDLE.
REQ-014 FETCH: drive mem_addr=addr for one cycle -> EVAL; EVAL samples mem_data.
REQ-015 EVAL: byte==TERM_BYTE or sent_cnt==MAX_LEN -> DONE; byte==SKIP0/SKIP1 -> addr+1, FETCH; else POLL_AR.
REQ-016 POLL_AR: arvalid=1, araddr=4'h8 until arready -> POLL_R; POLL_R: rready=1 until rvalid.
REQ-017 On rvalid: rdata[3]=1 (TX FIFO full) -> POLL_AR; else WRITE; rresp!=0 sets err, proceeds as full.
REQ-018 WRITE: awvalid and wvalid asserted together, awaddr=4'h4, wdata=held byte; each drops independently on its own handshake; both done -> RESP.
REQ-019 AW and W handshakes SHALL be accepted in either order or same cycle; valids SHALL not drop before ready.
REQ-020 RESP: bready=1 until bvalid; bresp!=0 sets err; then addr+1, sent_cnt+1, go GAP (or FETCH when GAP_CYCLES=0).
REQ-021 GAP: count GAP_CYCLES clocks exactly, then FETCH.
REQ-022 addr SHALL wrap modulo 2**ADDR_WIDTH without error.
REQ-023 DONE: done=1 for exactly one clock -> IDLE; busy=1 in all states except IDLE.
REQ-024 abort in FETCH/EVAL/GAP/POLL_AR-before-issue -> DONE next clock; abort during an issued AXI transaction SHALL be latched and honoured after RESP or POLL_R completes.
REQ-025 abort and start simultaneously in IDLE -> start ignored.
REQ-026 sent_cnt counts transmitted bytes only (skips excluded), holds after DONE until next start.

Reset
REQ-027 Reset SHALL force IDLE; busy, done, err, awvalid, wvalid, bready, arvalid, rready = 0; sent_cnt, mem_addr, awaddr, araddr, wdata = 0; gap counter and abort latch cleared.
REQ-028 Reset mid-transaction SHALL drop all valids immediately; no partial write continued after release.

Structure
REQ-029 Package uart_msg_pkg SHALL hold state encoding, register offsets TX_FIFO=4'h4, STAT=4'h8, status bit TX_FULL=3.
REQ-030 One sub-module axil_wr_beat SHALL implement the AW/W/B single-beat write handshake.

Verification
REQ-031 ROM "HI\0" at base 0, zero-wait slave: wdata 8'h48, 8'h49, sent_cnt=2, one done pulse, err=0.
REQ-032 ROM 48 E4 FF 49 00: only 8'h48, 8'h49 written, sent_cnt=2.
REQ-033 Status returns 8'h08 three times then 8'h00: three extra AR reads, single write of first byte.
REQ-034 wready 3 clk before awready, then reversed next byte: one write each, valids held until their ready.
REQ-035 bresp=2'b10 on byte 1 of 3: err=1 sticky, all 3 bytes sent; abort during GAP -> done next clock.
REQ-036 msg_base=7'h7E, bytes at 7E,7F,00 then TERM at 01: addr wraps, 3 bytes sent.

Source files
------------

// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message streamer: controller states and
// the register map of the AXI-Lite UART it talks to.
package uart_msg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    EVAL,
    POLL_AR,
    POLL_R,
    WRITE,
    RESP,
    GAP,
    DONE
  } state_t;

  localparam logic [3:0] TX_FIFO = 4'h4;
  localparam logic [3:0] STAT    = 4'h8;
  localparam int         TX_FULL = 3;

endpackage

// File: rtl/axil_wr_beat.sv
// Single-beat AXI-Lite write: AW and W are raised together, each drops on its
// own handshake, then B is accepted once both address and data have gone out.
module axil_wr_beat (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  output logic [3:0] awaddr,
  output logic       awvalid,
  input  logic       awready,
  output logic [7:0] wdata,
  output logic       wvalid,
  input  logic       wready,
  input  logic [1:0] bresp,
  input  logic       bvalid,
  output logic       bready,
  output logic       data_done,
  output logic       resp_done,
  output logic       resp_err
);

  logic [3:0] awaddr_q, awaddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       awvalid_q, awvalid_d;
  logic       wvalid_q, wvalid_d;
  logic       bready_q, bready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  // bready rises in the same edge that retires the last of AW/W.
  always_comb begin
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    data_done = 1'b0;
    if (go) begin
      awaddr_d  = addr;
      wdata_d   = data;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end else begin
      if (awvalid_q && awready) awvalid_d = 1'b0;
      if (wvalid_q && wready)   wvalid_d  = 1'b0;
      if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) begin
        bready_d  = 1'b1;
        data_done = 1'b1;
      end
      if (bready_q && bvalid) bready_d = 1'b0;
    end
  end

  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign resp_done = bready_q && bvalid;
  assign resp_err  = bready_q && bvalid && (bresp != 2'b00);

endmodule

// File: rtl/uart_msg_streamer.sv
// Streams a terminated byte string from a synchronous message memory into an
// AXI-Lite UART, polling the TX-full status bit before every byte.
module uart_msg_streamer
  import uart_msg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 7,
  parameter int          MAX_LEN    = 127,
  parameter int          GAP_CYCLES = 16,
  parameter logic [7:0]  TERM_BYTE  = 8'h00,
  parameter logic [7:0]  SKIP0      = 8'hE4,
  parameter logic [7:0]  SKIP1      = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] msg_base,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic [3:0]            awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [7:0]            wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [3:0]            araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [7:0]            rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            sent_cnt
);

  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            sent_cnt_q, sent_cnt_d;
  logic [7:0]            byte_q, byte_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;
  logic                  wr_go, wr_data_done, wr_resp_done, wr_resp_err;
  logic                  unused_rdata;

  assign unused_rdata = ^{rdata[7:TX_FULL+1], rdata[TX_FULL-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sent_cnt_q <= '0;
      byte_q     <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sent_cnt_q <= sent_cnt_d;
      byte_q     <= byte_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  // Once an AR or AW/W has been handed out, abort is only remembered and acted
  // on when that transaction has fully finished, so the bus never sees a cut.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sent_cnt_d = sent_cnt_q;
    byte_d     = byte_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;
    abort_d    = abort_q;
    wr_go      = 1'b0;
    arvalid    = 1'b0;
    araddr     = '0;
    rready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          addr_d     = msg_base;
          sent_cnt_d = '0;
          err_d      = 1'b0;
          abort_d    = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = abort ? DONE : EVAL;
      EVAL: begin
        byte_d = mem_data;
        if (abort || mem_data == TERM_BYTE || sent_cnt_q == 8'(MAX_LEN)) begin
          state_d = DONE;
        end else if (mem_data == SKIP0 || mem_data == SKIP1) begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end else begin
          state_d = POLL_AR;
        end
      end
      POLL_AR: begin
        arvalid = 1'b1;
        araddr  = STAT;
        if (arready) begin
          if (abort) abort_d = 1'b1;
          state_d = POLL_R;
        end else if (abort) begin
          state_d = DONE;
        end
      end
      POLL_R: begin
        rready = 1'b1;
        if (abort) abort_d = 1'b1;
        if (rvalid) begin
          if (rresp != 2'b00) err_d = 1'b1;
          if (abort_q || abort) begin
            state_d = DONE;
          end else if (rdata[TX_FULL] || rresp != 2'b00) begin
            state_d = POLL_AR;
          end else begin
            wr_go   = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) abort_d = 1'b1;
        if (wr_data_done) state_d = RESP;
      end
      RESP: begin
        if (abort) abort_d = 1'b1;
        if (wr_resp_done) begin
          if (wr_resp_err) err_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          sent_cnt_d = sent_cnt_q + 1'b1;
          gap_cnt_d  = '0;
          if (abort_q || abort)  state_d = DONE;
          else if (GAP_CYCLES == 0) state_d = FETCH;
          else                   state_d = GAP;
        end
      end
      GAP: begin
        if (abort)                            state_d = DONE;
        else if (gap_cnt_q == GW'(GAP_LAST))  state_d = FETCH;
        else                                  gap_cnt_d = gap_cnt_q + 1'b1;
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  axil_wr_beat u_wr (
    .clk       (clk),
    .rst       (rst),
    .go        (wr_go),
    .addr      (TX_FIFO),
    .data      (byte_q),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .data_done (wr_data_done),
    .resp_done (wr_resp_done),
    .resp_err  (wr_resp_err)
  );

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Bench for uart_msg_streamer: memory model, reactive AXI-Lite UART slave and
// a message-level reference model that predicts the bytes written.
module tb_uart_msg_streamer;

  localparam int         MAXL = 127;
  localparam int         GAPC = 16;
  localparam logic [7:0] TERM = 8'h00;
  localparam logic [7:0] SK0  = 8'hE4;
  localparam logic [7:0] SK1  = 8'hFF;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] msg_base = '0;
  logic [6:0] mem_addr;
  logic [7:0] mem_data = '0;
  logic [3:0] awaddr, araddr;
  logic       awvalid, wvalid, bready, arvalid, rready;
  logic       awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic       arready = 1'b0, rvalid = 1'b0;
  logic [7:0] wdata;
  logic [7:0] rdata = '0;
  logic [1:0] bresp = '0, rresp = '0;
  logic       busy, done, err;
  logic [7:0] sent_cnt;

  logic [7:0] rom [0:127];
  logic [9:0] stat_q[$];

  int checks = 0;
  int errors = 0;

  // slave configuration
  int aw_lat[2] = '{0, 0};
  int w_lat[2]  = '{0, 0};
  int ar_lat    = 0;
  bit rand_lat  = 0;
  int bad_b_idx = -1;

  // monitor state
  int  cyc = 0, ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int  done_cnt = 0, hold_viol = 0, addr_bad = 0, last_gap = 0, b_cyc = 0;
  bit  b_seen = 0, arv_prev = 0, aw_pend = 0, w_pend = 0;
  bq_t wq;

  // driver state
  int r_issued = 0, b_issued = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, aw_cur = 0, w_cur = 0, ar_cur = 0;
  bit aw_act = 0, w_act = 0, ar_act = 0;

  uart_msg_streamer #(
    .ADDR_WIDTH (7),
    .MAX_LEN    (MAXL),
    .GAP_CYCLES (GAPC),
    .TERM_BYTE  (TERM),
    .SKIP0      (SK0),
    .SKIP1      (SK1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg_base (msg_base),
    .abort    (abort),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  // synchronous message memory: data one clock after the address
  always @(posedge clk) mem_data <= rom[mem_addr];

  // bus monitor: sampled values are the ones in force just before the edge
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if ((aw_pend && !awvalid) || (w_pend && !wvalid)) hold_viol++;
      if (arvalid && arready) begin
        ar_cnt++;
        if (araddr != 4'h8) addr_bad++;
      end
      if (rvalid && rready) r_cnt++;
      if (awvalid && awready) begin
        aw_cnt++;
        if (awaddr != 4'h4) addr_bad++;
      end
      if (wvalid && wready) begin
        w_cnt++;
        wq.push_back(wdata);
      end
      if (bvalid && bready) begin
        b_cnt++;
        b_cyc  = cyc;
        b_seen = 1;
      end
      if (arvalid && !arv_prev && b_seen) begin
        last_gap = cyc - b_cyc;
        b_seen   = 0;
      end
      if (done) begin
        done_cnt++;
        b_seen = 0;
      end
    end
    aw_pend  = awvalid && !awready && !rst;
    w_pend   = wvalid && !wready && !rst;
    arv_prev = arvalid;
  end

  // reactive UART slave, driven on the falling edge
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      aw_act = 0; w_act = 0; ar_act = 0;
    end else begin
      if (arvalid) begin
        if (!ar_act) begin
          ar_act = 1; ar_wait = 0;
          ar_cur = rand_lat ? int'($urandom_range(0, 3)) : ar_lat;
        end
        if (ar_wait >= ar_cur) arready = 1;
        else begin arready = 0; ar_wait++; end
      end else begin
        arready = 0; ar_act = 0;
      end

      if (rvalid && r_cnt == r_issued) rvalid = 0;
      if (!rvalid && ar_cnt > r_issued) begin
        if (stat_q.size() > 0) e = stat_q.pop_front();
        else e = {2'b00, 8'($urandom) & 8'hF7};
        {rresp, rdata} = e;
        rvalid = 1;
        r_issued++;
      end

      if (awvalid) begin
        if (!aw_act) begin
          aw_act = 1; aw_wait = 0;
          aw_cur = rand_lat ? int'($urandom_range(0, 3)) : aw_lat[aw_cnt % 2];
        end
        if (aw_wait >= aw_cur) awready = 1;
        else begin awready = 0; aw_wait++; end
      end else begin
        awready = 0; aw_act = 0;
      end

      if (wvalid) begin
        if (!w_act) begin
          w_act = 1; w_wait = 0;
          w_cur = rand_lat ? int'($urandom_range(0, 3)) : w_lat[w_cnt % 2];
        end
        if (w_wait >= w_cur) wready = 1;
        else begin wready = 0; w_wait++; end
      end else begin
        wready = 0; w_act = 0;
      end

      if (bvalid && b_cnt == b_issued) bvalid = 0;
      if (!bvalid && aw_cnt > b_issued && w_cnt > b_issued) begin
        bvalid = 1;
        bresp  = (b_issued == bad_b_idx) ? 2'b10 : 2'b00;
        b_issued++;
      end
    end
  end

  // Message-level prediction: walk memory from base, drop skip bytes, stop at
  // the terminator or once MAXL bytes have been sent.
  function automatic bq_t modelMsg(input int base);
    bq_t        q;
    logic [7:0] b;
    int         a;
    a = base;
    for (int n = 0; n < 1000; n++) begin
      b = rom[a % 128];
      if (b == TERM || q.size() == MAXL) break;
      if (b != SK0 && b != SK1) q.push_back(b);
      a++;
    end
    return q;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] base, input int late_start, output bit finished);
    @(negedge clk);
    msg_base = base;
    start    = 1;
    @(negedge clk);
    start    = 0;
    finished = 0;
    for (int c = 0; c < 8000; c++) begin
      if (c == late_start) begin
        msg_base = base ^ 7'h40;
        start    = 1;
      end else begin
        start = 0;
      end
      @(negedge clk);
      if (done) begin
        finished = 1;
        break;
      end
    end
    start = 0;
    if (!finished) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic runMsg(input string tag, input logic [6:0] base, input int err_exp, input int late_start);
    bq_t expv;
    int  w0, d0;
    bit  fin;
    expv = modelMsg(base);
    w0   = wq.size();
    d0   = done_cnt;
    applyStimulus(base, late_start, fin);
    @(negedge clk);
    checkOutput({tag, "_done_width"}, done, 0);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_done_pulses"}, done_cnt - d0, 1);
    checkOutput({tag, "_nbytes"}, wq.size() - w0, expv.size());
    for (int i = 0; i < expv.size() && w0 + i < wq.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), wq[w0 + i], expv[i]);
    checkOutput({tag, "_sent_cnt"}, sent_cnt, expv.size());
    checkOutput({tag, "_err"}, err, err_exp);
  endtask

  initial begin
    int ar0, w0, b0, n;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;

    rst = 1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_sent", sent_cnt, 0);
    checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    checkOutput("rst_addrs", {mem_addr, awaddr, araddr, wdata}, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("[TB] HI message, zero-wait slave");
    rom[0] = 8'h48; rom[1] = 8'h49; rom[2] = 8'h00;
    ar0 = ar_cnt;
    runMsg("hi", 7'h00, 0, -1);
    checkOutput("hi_ar_reads", ar_cnt - ar0, 2);
    checkOutput("hi_gap_cycles", last_gap, GAPC + 3);

    $display("[TB] skip bytes");
    rom[10] = 8'h48; rom[11] = 8'hE4; rom[12] = 8'hFF; rom[13] = 8'h49; rom[14] = 8'h00;
    runMsg("skip", 7'd10, 0, -1);

    $display("[TB] TX FIFO full three times");
    rom[20] = 8'h41; rom[21] = 8'h00;
    for (int i = 0; i < 3; i++) stat_q.push_back({2'b00, 8'h08});
    stat_q.push_back({2'b00, 8'h00});
    ar0 = ar_cnt;
    runMsg("full", 7'd20, 0, -1);
    checkOutput("full_ar_reads", ar_cnt - ar0, 4);

    $display("[TB] status read error response");
    rom[30] = 8'h5A; rom[31] = 8'h00;
    stat_q.push_back({2'b10, 8'h00});
    ar0 = ar_cnt;
    runMsg("rresp", 7'd30, 1, -1);
    checkOutput("rresp_ar_reads", ar_cnt - ar0, 2);

    $display("[TB] AW/W ready ordering");
    rom[40] = 8'h50; rom[41] = 8'h51; rom[42] = 8'h00;
    n = aw_cnt % 2;
    aw_lat[n] = 3; w_lat[n] = 0; aw_lat[1 - n] = 0; w_lat[1 - n] = 3;
    runMsg("order", 7'd40, 0, -1);
    aw_lat = '{0, 0}; w_lat = '{0, 0};

    $display("[TB] bad write response on second byte");
    rom[50] = 8'h41; rom[51] = 8'h42; rom[52] = 8'h43; rom[53] = 8'h00;
    bad_b_idx = b_cnt + 1;
    runMsg("bresp", 7'd50, 1, -1);
    bad_b_idx = -1;

    $display("[TB] abort during inter-byte gap");
    rom[60] = 8'h56; rom[61] = 8'h57; rom[62] = 8'h58; rom[63] = 8'h59; rom[64] = 8'h00;
    w0 = wq.size(); b0 = b_cnt;
    @(negedge clk); msg_base = 7'd60; start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 300; i++) begin
      if (b_cnt > b0) break;
      @(negedge clk);
    end
    checkOutput("abort_first_write", b_cnt > b0, 1);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    checkOutput("abort_done_next", done, 1);
    @(negedge clk);
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_sent", sent_cnt, 1);
    checkOutput("abort_nbytes", wq.size() - w0, 1);
    checkOutput("abort_err_cleared", err, 0);

    $display("[TB] address wrap, with an ignored start mid-message");
    rom[126] = 8'h61; rom[127] = 8'h62; rom[0] = 8'h63; rom[1] = 8'h00;
    runMsg("wrap", 7'h7E, 0, 5);

    $display("[TB] start together with abort in idle");
    @(negedge clk); msg_base = 7'd0; start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    checkOutput("startabort_busy", busy, 0);
    @(negedge clk);
    checkOutput("startabort_busy2", busy, 0);

    $display("[TB] reset in the middle of a write");
    rom[70] = 8'h4D; rom[71] = 8'h00;
    aw_lat = '{10, 10}; w_lat = '{10, 10};
    w0 = wq.size();
    @(negedge clk); msg_base = 7'd70; start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 100; i++) begin
      if (awvalid) break;
      @(negedge clk);
    end
    checkOutput("rstmid_reached_write", awvalid, 1);
    rst = 1;
    #1;
    checkOutput("rstmid_valids_drop", {awvalid, wvalid, bready}, 0);
    checkOutput("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    checkOutput("rstmid_no_resume", {awvalid, wvalid, busy}, 0);
    checkOutput("rstmid_no_write", wq.size() - w0, 0);
    aw_lat = '{0, 0}; w_lat = '{0, 0};

    $display("[TB] maximum length message");
    for (int i = 0; i < 128; i++) rom[i] = 8'h55;
    runMsg("maxlen", 7'd5, 0, -1);

    $display("[TB] randomized messages");
    rand_lat = 1;
    for (int t = 0; t < 6; t++) begin
      logic [6:0] base;
      int         len;
      logic [7:0] v;
      base = 7'($urandom_range(0, 127));
      for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
      len = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) begin
        v = 8'($urandom);
        if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 1) ? SK0 : SK1;
        rom[(base + i) % 128] = v;
      end
      rom[(base + len) % 128] = TERM;
      for (int k = $urandom_range(0, 2); k > 0; k--)
        stat_q.push_back({2'b00, 8'($urandom) | 8'h08});
      runMsg($sformatf("rand%0d", t), base, 0, -1);
    end

    checkOutput("valid_hold", hold_viol, 0);
    checkOutput("reg_offsets", addr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
